// File: rtl/pixel_serializer.sv
// pixel_serializer
//   Serializes W-bit pixel words onto a single output bit, one bit per en
//   strobe, grouped into frames of N_WORDS words. After every frame (or an
//   aborted frame caused by missing data) the output is held low for
//   LATCH_STROBES strobes so the downstream shift chain can latch.
//
//   State table
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | output low, waiting for a word in the holding register
//   S_SHIFT | shifting a word out, bit_idx bits already presented
//   S_LATCH | output forced low, counting down LATCH_STROBES strobes
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   en         in   bit-period strobe; FSM/counters advance only when high
//   in_data    in   W-bit word to serialize
//   in_valid   in   in_data valid
//   in_ready   out  holding register empty
//   out        out  serial data bit (registered)
//   out_valid  out  out carries a data bit (registered)
//   word_done  out  pulse at the end of a word's last bit period
//   frame_done out  pulse when the last word of a frame completes
//   underrun   out  pulse when a frame is aborted for lack of data
module pixel_serializer #(
    parameter int W             = 24,
    parameter int N_WORDS       = 64,
    parameter int MSB_FIRST     = 1,
    parameter int LATCH_STROBES = 50
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         out,
    output logic         out_valid,
    output logic         word_done,
    output logic         frame_done,
    output logic         underrun
);

    localparam int BW = $clog2(W + 1);
    localparam int CW = $clog2(N_WORDS + 1);
    localparam int LW = $clog2(LATCH_STROBES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;

    localparam logic [BW-1:0] BIT_LAST   = BW'(W);
    localparam logic [CW-1:0] WORD_LAST  = CW'(N_WORDS - 1);
    localparam logic [LW-1:0] LATCH_INIT = LW'(LATCH_STROBES);

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic [W-1:0]  shift_q, shift_d;
    logic [BW-1:0] bit_idx_q, bit_idx_d;
    logic [CW-1:0] word_cnt_q, word_cnt_d;
    logic [LW-1:0] latch_cnt_q, latch_cnt_d;
    logic          out_q, out_d;
    logic          out_valid_q, out_valid_d;
    logic          word_done_q, word_done_d;
    logic          frame_done_q, frame_done_d;
    logic          underrun_q, underrun_d;

    // First bit of the holding word and the remainder left in the shifter.
    logic         hold_first;
    logic [W-1:0] hold_rest;
    logic         shift_next;
    logic [W-1:0] shift_rest;

    assign hold_first = (MSB_FIRST != 0) ? hold_q[W-1]  : hold_q[0];
    assign hold_rest  = (MSB_FIRST != 0) ? (hold_q << 1) : (hold_q >> 1);
    assign shift_next = (MSB_FIRST != 0) ? shift_q[W-1] : shift_q[0];
    assign shift_rest = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);

    assign in_ready   = ~hold_full_q;
    assign out        = out_q;
    assign out_valid  = out_valid_q;
    assign word_done  = word_done_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        shift_d      = shift_q;
        bit_idx_d    = bit_idx_q;
        word_cnt_d   = word_cnt_q;
        latch_cnt_d  = latch_cnt_q;
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        word_done_d  = 1'b0;
        frame_done_d = 1'b0;
        underrun_d   = 1'b0;

        // Accept only into an empty holding register. Transfer below needs
        // hold_full_q=1, so accept and transfer can never share an edge.
        if (in_valid && !hold_full_q) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end

        if (en) begin
            case (state_q)
                S_IDLE: begin
                    out_d       = 1'b0;
                    out_valid_d = 1'b0;
                    if (hold_full_q) begin
                        shift_d     = hold_rest;
                        out_d       = hold_first;
                        out_valid_d = 1'b1;
                        hold_full_d = 1'b0;
                        bit_idx_d   = BW'(1);
                        state_d     = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (bit_idx_q < BIT_LAST) begin
                        out_d     = shift_next;
                        shift_d   = shift_rest;
                        bit_idx_d = bit_idx_q + BW'(1);
                    end else begin
                        word_done_d = 1'b1;
                        if (word_cnt_q == WORD_LAST) begin
                            frame_done_d = 1'b1;
                            word_cnt_d   = '0;
                            bit_idx_d    = '0;
                            out_d        = 1'b0;
                            out_valid_d  = 1'b0;
                            latch_cnt_d  = LATCH_INIT;
                            state_d      = S_LATCH;
                        end else if (hold_full_q) begin
                            // Back-to-back reload: next word's first bit
                            // goes out on the same edge, no gap strobe.
                            word_cnt_d  = word_cnt_q + CW'(1);
                            shift_d     = hold_rest;
                            out_d       = hold_first;
                            hold_full_d = 1'b0;
                            bit_idx_d   = BW'(1);
                        end else begin
                            underrun_d  = 1'b1;
                            word_cnt_d  = '0;
                            bit_idx_d   = '0;
                            out_d       = 1'b0;
                            out_valid_d = 1'b0;
                            latch_cnt_d = LATCH_INIT;
                            state_d     = S_LATCH;
                        end
                    end
                end
                S_LATCH: begin
                    out_d       = 1'b0;
                    out_valid_d = 1'b0;
                    if (latch_cnt_q <= LW'(1)) begin
                        latch_cnt_d = '0;
                        state_d     = S_IDLE;
                    end else begin
                        latch_cnt_d = latch_cnt_q - LW'(1);
                    end
                end
                default: begin
                    out_d       = 1'b0;
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            word_cnt_q   <= '0;
            latch_cnt_q  <= '0;
            out_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            word_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            shift_q      <= shift_d;
            bit_idx_q    <= bit_idx_d;
            word_cnt_q   <= word_cnt_d;
            latch_cnt_q  <= latch_cnt_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            word_done_q  <= word_done_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
        end
    end

endmodule

// File: tb/tb_pixel_serializer.sv
module tb_pixel_serializer;

    localparam int W  = 24;
    localparam int NW = 2;
    localparam int LS = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready, out, out_valid, word_done, frame_done, underrun;

    logic         lsb_valid = 1'b0;
    logic [W-1:0] lsb_data = '0;
    logic         lsb_ready, lsb_out, lsb_ov, lsb_wd, lsb_fd, lsb_ur;

    int n_tests = 0;
    int n_fail  = 0;
    bit en_pause = 1'b0;

    always #5 clk = ~clk;

    pixel_serializer #(.W(W), .N_WORDS(NW), .MSB_FIRST(1), .LATCH_STROBES(LS)) u_dut (
        .clk(clk), .rst(rst), .en(en), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out(out), .out_valid(out_valid), .word_done(word_done),
        .frame_done(frame_done), .underrun(underrun));

    pixel_serializer #(.W(W), .N_WORDS(1), .MSB_FIRST(0), .LATCH_STROBES(LS)) u_lsb (
        .clk(clk), .rst(rst), .en(en), .in_data(lsb_data), .in_valid(lsb_valid),
        .in_ready(lsb_ready), .out(lsb_out), .out_valid(lsb_ov), .word_done(lsb_wd),
        .frame_done(lsb_fd), .underrun(lsb_ur));

    // en strobe: one clk in four, suppressible for the freeze test
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            ph = (ph + 1) % 4;
            en = (ph == 0) && !en_pause;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + monitor ----------------
    // Model: a queue of accepted words, the bits still to send of the
    // current word, words finished in this frame, and remaining latch strobes.
    logic [W-1:0] exp_words[$];
    bit           cur_bits[$];
    bit           active = 1'b0;
    int           latch_left = 0;
    int           words_done = 0;
    bit           exp_out = 1'b0, exp_ov = 1'b0;
    bit           e_wd, e_fd, e_ur;
    bit           last_en = 1'b0, last_acc = 1'b0, last_rst = 1'b1;
    logic [W-1:0] last_data = '0;
    logic [5:0]   got, expv;
    int           n_wd = 0, n_fd = 0, n_ur = 0, n_acc = 0;

    task automatic load_next();
        logic [W-1:0] wv;
        wv = exp_words.pop_front();
        cur_bits.delete();
        for (int i = W - 1; i >= 0; i--) cur_bits.push_back(wv[i]);
        exp_out = cur_bits.pop_front();
        exp_ov  = 1'b1;
        active  = 1'b1;
    endtask

    task automatic end_frame();
        words_done = 0;
        active     = 1'b0;
        latch_left = LS;
        exp_out    = 1'b0;
        exp_ov     = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst || last_rst) begin
            exp_words.delete();
            cur_bits.delete();
            active = 1'b0; latch_left = 0; words_done = 0;
            exp_out = 1'b0; exp_ov = 1'b0;
        end else begin
            e_wd = 1'b0; e_fd = 1'b0; e_ur = 1'b0;
            if (last_en) begin
                if (latch_left > 0) begin
                    latch_left--;
                end else if (!active) begin
                    if (exp_words.size() > 0) load_next();
                end else if (cur_bits.size() > 0) begin
                    exp_out = cur_bits.pop_front();
                end else begin
                    e_wd = 1'b1;
                    words_done++;
                    if (words_done == NW) begin
                        e_fd = 1'b1;
                        end_frame();
                    end else if (exp_words.size() > 0) begin
                        load_next();
                    end else begin
                        e_ur = 1'b1;
                        end_frame();
                    end
                end
            end
            // a word accepted on this edge is not yet visible to transfer
            if (last_acc) begin
                exp_words.push_back(last_data);
                n_acc++;
            end
            got  = {out, out_valid, word_done, frame_done, underrun, in_ready};
            expv = {exp_out, exp_ov, e_wd, e_fd, e_ur, exp_words.size() == 0};
            n_tests++;
            if (got !== expv) begin
                n_fail++;
                $display("FAIL stream {out,ov,wd,fd,ur,rdy}: got %b, expected %b (t=%0t)",
                         got, expv, $time);
            end
            n_wd += int'(word_done);
            n_fd += int'(frame_done);
            n_ur += int'(underrun);
        end
        last_en   = en;
        last_acc  = in_valid && in_ready;
        last_data = in_data;
        last_rst  = rst;
    end

    // ---------------- stimulus ----------------
    task automatic send_word(input logic [W-1:0] d, input bit keep);
        bit r;
        bit ok;
        if (!in_valid) begin
            @(posedge clk);
            #1;
        end
        in_data  = d;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 0, 1);
        if (!keep || !ok) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            if (!active && latch_left == 0 && exp_words.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 0, 1);
    endtask

    task automatic wait_bits_sent(input int k);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            if (active && words_done == 0 && cur_bits.size() == W - k) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("position_timeout", 0, 1);
    endtask

    initial begin
        int s_fd, s_wd, s_ur;
        int nb, fd_seen, ur_seen;
        bit pe, first;
        logic [W-1:0] cap;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", int'({out, out_valid, word_done, frame_done, underrun}), 0);
        check("reset_in_ready", int'(in_ready), 1);
        rst = 1'b0;

        // LSB-first instance: 0x000001 gives a 1 followed by 23 zeros
        @(posedge clk);
        #1;
        lsb_data  = 24'h000001;
        lsb_valid = 1'b1;
        @(negedge clk);
        check("lsb_ready_before", int'(lsb_ready), 1);
        @(posedge clk);
        #1;
        lsb_valid = 1'b0;
        nb = 0; cap = '1; pe = 1'b0; first = 1'b0;
        for (int c = 0; c < 600 && nb < W; c++) begin
            @(negedge clk);
            if (pe && lsb_ov) begin
                if (nb == 0) first = lsb_out;
                cap[nb] = lsb_out;
                nb++;
            end
            pe = en;
        end
        check("lsb_bit_count", nb, W);
        check("lsb_first_bit", int'(first), 1);
        check("lsb_word", int'(cap), 1);
        fd_seen = 0; ur_seen = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            fd_seen += int'(lsb_fd);
            ur_seen += int'(lsb_ur);
        end
        check("lsb_frame_done", fd_seen, 1);
        check("lsb_underrun", ur_seen, 0);

        // directed frame 0xFF0000, 0x00FF00
        send_word(24'hFF0000, 1'b0);
        send_word(24'h00FF00, 1'b0);
        wait_idle();
        check("frame1_word_done", n_wd, 2);
        check("frame1_frame_done", n_fd, 1);
        check("frame1_underrun", n_ur, 0);

        // single word -> underrun together with word_done
        send_word(W'($urandom), 1'b0);
        wait_idle();
        check("underrun_count", n_ur, 1);
        check("underrun_word_done", n_wd, 3);
        check("underrun_no_frame", n_fd, 1);

        // in_valid held high for 6 words
        for (int i = 0; i < 6; i++) send_word(W'($urandom), 1'b1);
        in_valid = 1'b0;
        wait_idle();
        check("stream_frames", n_fd, 4);
        check("stream_words", n_wd, 9);
        check("stream_accepts", n_acc, 9);

        // random words with random gaps
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 150)) @(posedge clk);
            send_word(W'($urandom), 1'b0);
        end
        wait_idle();
        check("random_accepts", n_acc, 29);
        check("random_word_count", n_wd, 29);

        // en low for 100 clk mid-word
        s_fd = n_fd;
        send_word(W'($urandom), 1'b0);
        send_word(W'($urandom), 1'b0);
        wait_bits_sent(7);
        en_pause = 1'b1;
        repeat (100) @(posedge clk);
        en_pause = 1'b0;
        wait_idle();
        check("pause_frame_done", n_fd, s_fd + 1);

        // asynchronous reset at strobe 10 of word 1
        s_fd = n_fd; s_wd = n_wd; s_ur = n_ur;
        send_word(W'($urandom), 1'b0);
        send_word(W'($urandom), 1'b0);
        wait_bits_sent(10);
        @(posedge clk);
        #3;
        check("pre_reset_valid", int'(out_valid), 1);
        check("pre_reset_ready", int'(in_ready), 0);
        rst = 1'b1;
        #1;
        check("async_reset_outputs", int'({out, out_valid, word_done, frame_done, underrun}), 0);
        check("async_reset_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        check("reset_no_pulses", n_wd + n_fd + n_ur, s_wd + s_fd + s_ur);
        send_word(W'($urandom), 1'b0);
        send_word(W'($urandom), 1'b0);
        wait_idle();
        check("post_reset_frame", n_fd, s_fd + 1);
        check("post_reset_words", n_wd, s_wd + 2);
        check("post_reset_underrun", n_ur, s_ur);

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pixel_serializer.md
PIXEL_SERIALIZER -- requirements
Module: pixel_serializer

Interface
REQ-001 SHALL have parameter W, default 24: bits per word (pixel), 2..32.
REQ-002 SHALL have parameter N_WORDS, default 64: words per frame, >=1.
REQ-003 SHALL have parameter MSB_FIRST, default 1: 1 = bit W-1 first, 0 = bit 0 first.
REQ-004 SHALL have parameter LATCH_STROBES, default 50: en strobes of forced-low latch after each frame, >=1.
REQ-005 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port en  input  1  bit-period strobe; all state advances only in cycles with en=1.
REQ-008 SHALL have port in_data  input  W  word to serialize.
REQ-009 SHALL have port in_valid  input  1  in_data valid.
REQ-010 SHALL have port in_ready  output  1  holding register empty, equal to ~hold_full (combinational).
REQ-011 SHALL have port out  output  1  serial bit, registered.
REQ-012 SHALL have port out_valid  output  1  out carries a data bit, registered.
REQ-013 SHALL have port word_done  output  1  one-cycle pulse when a word's last bit period ends.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse when word N_WORDS of a frame completes.
REQ-015 SHALL have port underrun  output  1  one-cycle pulse when a frame is aborted for lack of data.

Function
REQ-016 SHALL accept in_data into a W-bit holding register on any clk edge with in_valid=1 and in_ready=1, independent of en and state.
REQ-017 SHALL implement states IDLE, SHIFT, LATCH; the transitions listed below SHALL occur only on edges with en=1.
REQ-018 IDLE: out=0, out_valid=0; on en with hold_full=1, SHALL move holding to shift register, clear hold_full, drive first bit on out, set out_valid=1, bit_idx=1, go SHIFT.
REQ-019 SHIFT, en with bit_idx<W: SHALL drive the next bit in the MSB_FIRST order and increment bit_idx.
REQ-020 SHIFT, en with bit_idx==W: SHALL pulse word_done and increment word_cnt.
REQ-021 When word_cnt reaches N_WORDS in REQ-020: SHALL also pulse frame_done, clear word_cnt, and enter LATCH with out=0, out_valid=0.
REQ-022 When the frame is not complete and hold_full=1 in REQ-020: SHALL load the next word and drive its first bit on the same edge, with no gap strobe.
REQ-023 When the frame is not complete and hold_full=0 in REQ-020: SHALL pulse underrun, clear word_cnt, and enter LATCH with out=0, out_valid=0.
REQ-024 LATCH: SHALL hold out=0 for exactly LATCH_STROBES en strobes, then go IDLE; the holding register SHALL still accept a word during LATCH.
REQ-025 A word accepted while hold_full=0 SHALL become visible to the en-qualified transfer logic on the following edge; accept and transfer SHALL NOT both occur on the same edge.
REQ-026 With en=0, out, out_valid, bit_idx, word_cnt and state SHALL hold; word_done, frame_done and underrun SHALL be 0.
REQ-027 Counters SHALL be sized $clog2(W+1), $clog2(N_WORDS+1) and $clog2(LATCH_STROBES+1) bits, with no wrap before their terminal values.
REQ-028 word_done, frame_done and underrun SHALL be high for exactly one clk cycle per event.

Reset
REQ-029 On rst=1, SHALL immediately force: state=IDLE, hold_full=0 (in_ready=1), out=0, out_valid=0, word_done=0, frame_done=0, underrun=0, bit_idx=0, word_cnt=0, latch counter=0.
REQ-030 Reset mid-word or mid-frame SHALL discard the shift and holding contents; no pulse SHALL be emitted for the aborted frame.

Verification (W=24, N_WORDS=2, MSB_FIRST=1, LATCH_STROBES=3, en every 4th clk)
REQ-031 Write 0xFF0000, then 0x00FF00 -> out sequence is 8x1,16x0,8x0,8x1,8x0 over 48 strobes with out_valid=1 throughout; word_done at strobes 24 and 48; frame_done with the second word_done; then 3 strobes with out=0, then IDLE.
REQ-032 MSB_FIRST=0, single word 0x000001 -> first out bit is 1, followed by 23 zeros.
REQ-033 Write one word only -> after 24 strobes, underrun and word_done pulse together, frame_done=0, LATCH entered, word_cnt=0.
REQ-034 in_valid held high continuously -> in_ready drops after the first accept, reloads occur with no gap strobe, and no word is lost or duplicated.
REQ-035 Assert rst at strobe 10 of word 1 -> all outputs 0 and in_ready=1 in the same cycle, asynchronously; next frame starts cleanly from word 0.
REQ-036 en=0 for 100 clk mid-word -> out and all counters frozen; the sequence resumes at the correct bit.
